// File: rtl/slink_rx_align_ctrl.sv
// Alignment sequencer for the S-Link RX align/deskew datapath: runs block-align,
// waits for lock on the active lanes, then waits for deskew, retrying on timeout.
module slink_rx_align_ctrl #(
  parameter int         NUM_LANES      = 4,
  parameter int         BA_HOLD_CYCLES = 16,
  parameter int         LOCK_TIMEOUT   = 1024,
  parameter int         DESKEW_TIMEOUT = 2048,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [1:0] DESKEW_DONE    = 2'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           active_lanes,
  input  logic [NUM_LANES-1:0] lane_locked,
  input  logic [1:0]           deskew_state,
  output logic                 enable,
  output logic                 blockalign,
  output logic                 rx_aligned,
  output logic                 align_err,
  output logic                 lock_lost,
  output logic [3:0]           retry_cnt,
  output logic [2:0]           ctrl_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BALIGN  = 3'd1;
  localparam logic [2:0] S_WLOCK   = 3'd2;
  localparam logic [2:0] S_DESKEW  = 3'd3;
  localparam logic [2:0] S_ALIGNED = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam int T_MAX0 = (LOCK_TIMEOUT > DESKEW_TIMEOUT) ? LOCK_TIMEOUT : DESKEW_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > BA_HOLD_CYCLES) ? T_MAX0 : BA_HOLD_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] BA_LAST     = TW'(BA_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] DESKEW_LAST = TW'(DESKEW_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  logic [2:0]           state_q, state_d;
  logic [3:0]           retry_q, retry_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           lanes_q;
  logic                 enable_q, blockalign_q, rx_aligned_q, align_err_q, lock_lost_q;
  logic                 lost_d, clr_timer, do_retry, lanes_chg;
  logic [NUM_LANES-1:0] lane_mask;
  logic                 all_locked;

  // Lanes at or above 1<<active_lanes are ignored; oversize counts naturally cover every lane.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_mask[i] = (i < (1 << active_lanes));
    end
  end

  assign all_locked = &(lane_locked | ~lane_mask);
  assign lanes_chg  = (active_lanes != lanes_q);

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    lost_d    = 1'b0;
    clr_timer = 1'b0;
    do_retry  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BALIGN;
          retry_d   = '0;
          clr_timer = 1'b1;
        end
      end
      S_BALIGN: begin
        if (timer_q == BA_LAST) begin
          state_d   = S_WLOCK;
          clr_timer = 1'b1;
        end
      end
      S_WLOCK: begin
        if (all_locked) begin
          state_d   = S_DESKEW;
          clr_timer = 1'b1;
        end else if (timer_q == LOCK_LAST) begin
          do_retry = 1'b1;
        end
      end
      S_DESKEW: begin
        if (all_locked && (deskew_state == DESKEW_DONE)) begin
          state_d   = S_ALIGNED;
          clr_timer = 1'b1;
        end else if (!all_locked || (timer_q == DESKEW_LAST)) begin
          do_retry = 1'b1;
        end
      end
      S_ALIGNED: begin
        if (!all_locked) begin
          state_d   = S_BALIGN;
          retry_d   = '0;
          lost_d    = 1'b1;
          clr_timer = 1'b1;
        end
      end
      S_ERROR: ;
      default: begin
        state_d   = S_IDLE;
        clr_timer = 1'b1;
      end
    endcase

    if (do_retry) begin
      clr_timer = 1'b1;
      if (retry_q < RETRY_MAX) begin
        state_d = S_BALIGN;
        retry_d = retry_q + 4'd1;
      end else begin
        state_d = S_ERROR;
      end
    end

    // A lane-count change invalidates any lock already acquired, so start over.
    if (lanes_chg && (state_q != S_IDLE) && (state_q != S_ERROR)) begin
      state_d   = S_BALIGN;
      retry_d   = retry_q;
      lost_d    = 1'b0;
      clr_timer = 1'b1;
    end

    if (!start) begin
      state_d   = S_IDLE;
      retry_d   = retry_q;
      lost_d    = 1'b0;
      clr_timer = 1'b1;
    end
  end

  always_comb begin
    if (clr_timer) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change together with ctrl_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      retry_q      <= '0;
      timer_q      <= '0;
      lanes_q      <= '0;
      enable_q     <= 1'b0;
      blockalign_q <= 1'b0;
      rx_aligned_q <= 1'b0;
      align_err_q  <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      lanes_q      <= active_lanes;
      enable_q     <= (state_d == S_BALIGN) || (state_d == S_WLOCK) ||
                      (state_d == S_DESKEW) || (state_d == S_ALIGNED);
      blockalign_q <= (state_d == S_BALIGN) || (state_d == S_WLOCK);
      rx_aligned_q <= (state_d == S_ALIGNED);
      align_err_q  <= (state_d == S_ERROR);
      lock_lost_q  <= lost_d;
    end
  end

  assign enable     = enable_q;
  assign blockalign = blockalign_q;
  assign rx_aligned = rx_aligned_q;
  assign align_err  = align_err_q;
  assign lock_lost  = lock_lost_q;
  assign retry_cnt  = retry_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_slink_rx_align_ctrl.sv
// Scoreboard bench for slink_rx_align_ctrl: expected output snapshots are queued
// as stimulus is applied and compared once the DUT has advanced.
module tb_slink_rx_align_ctrl;

  localparam logic [2:0] IDLE = 3'd0, BA = 3'd1, WL = 3'd2, DS = 3'd3, AL = 3'd4, ER = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] active_lanes;
  logic [3:0] lane_locked;
  logic [1:0] deskew_state;
  logic       enable, blockalign, rx_aligned, align_err, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] ctrl_state;

  slink_rx_align_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .active_lanes(active_lanes),
    .lane_locked(lane_locked), .deskew_state(deskew_state),
    .enable(enable), .blockalign(blockalign), .rx_aligned(rx_aligned),
    .align_err(align_err), .lock_lost(lock_lost), .retry_cnt(retry_cnt),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       en, ba, ra, ae, ll;
    logic [3:0] rc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   ba_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic exp_push(input string tag, input logic [2:0] st, input logic en, input logic ba,
                          input logic ra, input logic ae, input logic ll, input logic [3:0] rc);
    exp_t e;
    e.tag = tag; e.st = st; e.en = en; e.ba = ba; e.ra = ra; e.ae = ae; e.ll = ll; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, ".state"},      32'(ctrl_state), 32'(e.st));
      check_eq({e.tag, ".enable"},     32'(enable),     32'(e.en));
      check_eq({e.tag, ".blockalign"}, 32'(blockalign), 32'(e.ba));
      check_eq({e.tag, ".rx_aligned"}, 32'(rx_aligned), 32'(e.ra));
      check_eq({e.tag, ".align_err"},  32'(align_err),  32'(e.ae));
      check_eq({e.tag, ".lock_lost"},  32'(lock_lost),  32'(e.ll));
      check_eq({e.tag, ".retry_cnt"},  32'(retry_cnt),  32'(e.rc));
    end
  endtask

  // Advance n cycles; sample point is 1 ns after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (blockalign === 1'b1) ba_cycles++;
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while (ctrl_state !== s && k < budget) begin
      step(1);
      k++;
    end
    if (ctrl_state !== s) check_eq({tag, ".wait_timeout"}, 32'(ctrl_state), 32'(s));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; active_lanes = 3'd2; lane_locked = 4'h0; deskew_state = 2'd0;
    step(2);
    exp_push("reset", IDLE, 0, 0, 0, 0, 0, 4'd0);
    sb_pop();
    reset = 1'b1;
    step(2);

    // Nominal bring-up
    ba_cycles = 0;
    start = 1'b1;
    exp_push("nom_ba_entry", BA, 1, 1, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    exp_push("nom_ba_last", BA, 1, 1, 0, 0, 0, 4'd0);
    step(15); sb_pop();
    exp_push("nom_wl_entry", WL, 1, 1, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    step(4);
    lane_locked = 4'hF;
    exp_push("nom_deskew", DS, 1, 0, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    check_eq("nom_ba_cycles", 32'(ba_cycles), 32'd21);
    step(2);
    deskew_state = 2'd2;
    exp_push("nom_aligned", AL, 1, 0, 1, 0, 0, 4'd0);
    step(1); sb_pop();

    // Lock loss on lane 1 for a single cycle
    lane_locked = 4'b1101;
    exp_push("lost_pulse", BA, 1, 1, 0, 0, 1, 4'd0);
    step(1); sb_pop();
    lane_locked = 4'hF;
    exp_push("lost_after", BA, 1, 1, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    wait_state("relock", AL, 40);
    exp_push("relock", AL, 1, 0, 1, 0, 0, 4'd0);
    sb_pop();

    // Lane masking: two active lanes, only lanes 0/1 locked
    start = 1'b0;
    exp_push("mask_idle", IDLE, 0, 0, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    active_lanes = 3'd1; lane_locked = 4'b0011; start = 1'b1;
    wait_state("mask_al", AL, 40);
    exp_push("mask_al", AL, 1, 0, 1, 0, 0, 4'd0);
    sb_pop();

    // Oversize lane count clamps to all four lanes
    start = 1'b0; step(1);
    active_lanes = 3'd3; lane_locked = 4'hF; start = 1'b1;
    wait_state("clamp_al", AL, 40);
    exp_push("clamp_al", AL, 1, 0, 1, 0, 0, 4'd0);
    sb_pop();
    start = 1'b0; step(1);

    // Same stimulus with four active lanes: lock timeout after 1024 cycles
    active_lanes = 3'd2; lane_locked = 4'b0011; start = 1'b1;
    exp_push("to_ba", BA, 1, 1, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    exp_push("to_wl", WL, 1, 1, 0, 0, 0, 4'd0);
    step(16); sb_pop();
    exp_push("to_wl_last", WL, 1, 1, 0, 0, 0, 4'd0);
    step(1023); sb_pop();
    exp_push("retry1", BA, 1, 1, 0, 0, 0, 4'd1);
    step(1); sb_pop();

    // Retry exhaustion
    lane_locked = 4'h0;
    exp_push("retry2", BA, 1, 1, 0, 0, 0, 4'd2);
    step(1040); sb_pop();
    exp_push("retry3", BA, 1, 1, 0, 0, 0, 4'd3);
    step(1040); sb_pop();
    exp_push("error", ER, 0, 0, 0, 1, 0, 4'd3);
    step(1040); sb_pop();
    exp_push("error_hold", ER, 0, 0, 0, 1, 0, 4'd3);
    step(5); sb_pop();
    start = 1'b0;
    exp_push("error_exit", IDLE, 0, 0, 0, 0, 0, 4'd3);
    step(1); sb_pop();

    // Deskew timeout, then success on the retry
    lane_locked = 4'hF; deskew_state = 2'd0; start = 1'b1;
    exp_push("dsk_ba", BA, 1, 1, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    step(16);
    exp_push("dsk_entry", DS, 1, 0, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    exp_push("dsk_last", DS, 1, 0, 0, 0, 0, 4'd0);
    step(2047); sb_pop();
    exp_push("dsk_retry", BA, 1, 1, 0, 0, 0, 4'd1);
    step(1); sb_pop();
    deskew_state = 2'd2;
    exp_push("dsk_al", AL, 1, 0, 1, 0, 0, 4'd1);
    step(18); sb_pop();

    // Asynchronous reset in the middle of DESKEW
    start = 1'b0; step(1);
    deskew_state = 2'd0; start = 1'b1;
    step(17);
    exp_push("ar_ds", DS, 1, 0, 0, 0, 0, 4'd0);
    step(1); sb_pop();
    #2;
    reset = 1'b0;
    exp_push("ar_reset", IDLE, 0, 0, 0, 0, 0, 4'd0);
    #1; sb_pop();
    step(2);
    reset = 1'b1;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
